regfile_access_ctrl: RTL
========================

Name: regfile_access_ctrl

Overview:
- Initiator side of the register-file port. It is the block that drives register addresses, write data and regWrite into register_block, and collects read_data1/read_data2.
- Accepts one register-access request per instruction from the datapath over a valid/ready handshake.
- Sequences read-then-optional-write with deterministic settle and hold windows, then returns both operands over a valid/ready response.
- Sits between decode/writeback control and register_block. It replaces the ad-hoc combinational driving of the regfile ports.

Parameters:
- READ_WAIT, 2: cycles read addresses are held before read data is captured; legal range ≥1.
- WRITE_HOLD, 2: cycles regWrite is held high; legal range ≥1.
- ZERO_REG_PROTECT, 1: when 1, writes with rd==0 are suppressed (MIPS $zero).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_rs  in  5  first source register
- req_rt  in  5  second source register
- req_rd  in  5  destination register
- req_we  in  1  request includes a write
- req_wdata  in  32  write data
- rsp_valid  out  1  response data valid
- rsp_ready  in  1  consumer accepts response
- rsp_rs_data  out  32  captured value of rs
- rsp_rt_data  out  32  captured value of rt
- rf_read_reg1  out  6  to register_block read_reg1
- rf_read_reg2  out  6  to register_block read_reg2
- rf_read_data1  in  32  from register_block read_data1
- rf_read_data2  in  32  from register_block read_data2
- rf_write_reg  out  6  to register_block write_reg
- rf_write_data  out  32  to register_block write_data
- rf_regWrite  out  1  to register_block regWrite
- busy  out  1  state != IDLE

Behaviour:
- All outputs are registered. Reset is synchronous and active-low: while rst_n=0 at a clk edge, every output goes to 0 and the state goes to IDLE. req_ready rises on the first edge with rst_n=1.
- 5-bit register fields are zero-extended to 6 bits on every rf_* address port (MSB always 0).
- States: IDLE, READ, WSETUP, WPULSE, WHOLD, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch rs/rt/rd/we/wdata.
  - Drive rf_read_reg1={0,rs} and rf_read_reg2={0,rt} from the next cycle.
  - Load the counter with READ_WAIT and go to READ.
- READ:
  - Lasts exactly READ_WAIT cycles with addresses stable.
  - In the last cycle, capture rf_read_data1/2 into rsp_rs_data/rsp_rt_data.
  - Next state is WSETUP if we && !(ZERO_REG_PROTECT && rd==0); otherwise RESP.
- WSETUP: 1 cycle. rf_write_reg={0,rd} and rf_write_data=wdata are driven; rf_regWrite=0.
- WPULSE: WRITE_HOLD cycles with rf_regWrite=1; address and data stable.
- WHOLD: 1 cycle with rf_regWrite=0; address and data still stable, because the regfile also reacts to the falling edge of regWrite. Then go to RESP.
- RESP:
  - rsp_valid=1; rsp data is stable until the handshake.
  - On rsp_valid&&rsp_ready, go to IDLE; rsp_valid=0 and req_ready=1 on the next cycle.
- Ordering: reads always complete before the write of the same request. If rd==rs, the response returns the old value.
- Latency, accept at cycle T:
  - Read-only: rsp_valid first high at T+READ_WAIT+1.
  - With write: rsp_valid first high at T+READ_WAIT+WRITE_HOLD+3.
- req_ready=0 in every state except IDLE. Requests presented while busy are not consumed. req_* are sampled only at acceptance.
- Between requests, rf_read_reg*, rf_write_reg and rf_write_data hold their last values. Holding them avoids spurious regfile reads and writes.
- rf_regWrite is never high outside WPULSE. It is never high for a suppressed write.
- Reset mid-operation: outputs are zeroed on the next edge regardless of state. A write interrupted in WPULSE or WHOLD may already have committed; no rollback.
- Back-to-back requests: the earliest possible acceptance is the cycle after the RESP handshake. Throughput is at most 1 request per READ_WAIT+2 cycles.

Test Plan (defaults):
- Reset held 3 cycles, then released → during reset all outputs 0; req_ready=1 one cycle after release; busy=0.
- Read-only request rs=5, rt=9, we=0, with regs 5=0x11 and 9=0x22 → rsp_valid at T+3; rsp_rs_data=0x11, rsp_rt_data=0x22; rf_regWrite stays 0.
- Request rs=3, rt=4, rd=7, we=1, wdata=0xDEADBEEF → regWrite high for exactly cycles T+4..T+5; rf_write_reg=7 stable from T+3 to T+6; rsp_valid at T+7; a follow-up read of 7 returns 0xDEADBEEF.
- Request rd=0, we=1, wdata=0xFFFFFFFF → no regWrite pulse; rsp_valid at T+3; reg 0 still reads 0.
- rs=rd=2 (old value 0x5), we=1, wdata=0x9, and rsp_ready held low 4 cycles → rsp_rs_data=0x5, stable for all 4 cycles; req_ready=0 throughout; a new req_valid is not accepted until the cycle after rsp_ready.
- rst_n pulled low during WPULSE → next edge: rf_regWrite=0, rsp_valid=0, state IDLE; req_ready=1 after release.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// Register-file initiator: accepts one access request, reads both sources after a settle
// window, optionally pulses a write, then returns the captured operands.
module regfile_access_ctrl #(
    parameter int READ_WAIT        = 2,
    parameter int WRITE_HOLD       = 2,
    parameter bit ZERO_REG_PROTECT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rs_data,
    output logic [31:0] rsp_rt_data,
    output logic [5:0]  rf_read_reg1,
    output logic [5:0]  rf_read_reg2,
    input  logic [31:0] rf_read_data1,
    input  logic [31:0] rf_read_data2,
    output logic [5:0]  rf_write_reg,
    output logic [31:0] rf_write_data,
    output logic        rf_regWrite,
    output logic        busy
);

    localparam int CNT_MAX = (READ_WAIT > WRITE_HOLD) ? READ_WAIT : WRITE_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, READ, WSETUP, WPULSE, WHOLD, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         rd_q, rd_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;

    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rs_data_q, rsp_rs_data_d;
    logic [31:0]        rsp_rt_data_q, rsp_rt_data_d;
    logic [5:0]         rf_read_reg1_q, rf_read_reg1_d;
    logic [5:0]         rf_read_reg2_q, rf_read_reg2_d;
    logic [5:0]         rf_write_reg_q, rf_write_reg_d;
    logic [31:0]        rf_write_data_q, rf_write_data_d;
    logic               rf_regWrite_q, rf_regWrite_d;
    logic               busy_q, busy_d;
    logic               do_write;

    assign do_write = we_q && !(ZERO_REG_PROTECT && (rd_q == 5'd0));

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a signal unassigned,
        // which is what keeps this block from inferring latches.
        state_d         = state_q;
        cnt_d           = cnt_q;
        rd_d            = rd_q;
        we_d            = we_q;
        wdata_d         = wdata_q;
        rsp_rs_data_d   = rsp_rs_data_q;
        rsp_rt_data_d   = rsp_rt_data_q;
        rf_read_reg1_d  = rf_read_reg1_q;
        rf_read_reg2_d  = rf_read_reg2_q;
        rf_write_reg_d  = rf_write_reg_q;
        rf_write_data_d = rf_write_data_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    rf_read_reg1_d = {1'b0, req_rs};
                    rf_read_reg2_d = {1'b0, req_rt};
                    rd_d           = req_rd;
                    we_d           = req_we;
                    wdata_d        = req_wdata;
                    cnt_d          = CNT_W'(READ_WAIT);
                    state_d        = READ;
                end
            end
            READ: begin
                if (cnt_q == CNT_W'(1)) begin
                    rsp_rs_data_d = rf_read_data1;
                    rsp_rt_data_d = rf_read_data2;
                    if (do_write) begin
                        rf_write_reg_d  = {1'b0, rd_q};
                        rf_write_data_d = wdata_q;
                        state_d         = WSETUP;
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WSETUP: begin
                cnt_d   = CNT_W'(WRITE_HOLD);
                state_d = WPULSE;
            end
            WPULSE: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = WHOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            // regWrite has just fallen; the regfile may still sample address/data here.
            WHOLD: state_d = RESP;
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake and strobe outputs are registered images of the next state.
        req_ready_d   = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
        rsp_valid_d   = (state_d == RESP);
        rf_regWrite_d = (state_d == WPULSE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            rd_q            <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            req_ready_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_rs_data_q   <= '0;
            rsp_rt_data_q   <= '0;
            rf_read_reg1_q  <= '0;
            rf_read_reg2_q  <= '0;
            rf_write_reg_q  <= '0;
            rf_write_data_q <= '0;
            rf_regWrite_q   <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rd_q            <= rd_d;
            we_q            <= we_d;
            wdata_q         <= wdata_d;
            req_ready_q     <= req_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rs_data_q   <= rsp_rs_data_d;
            rsp_rt_data_q   <= rsp_rt_data_d;
            rf_read_reg1_q  <= rf_read_reg1_d;
            rf_read_reg2_q  <= rf_read_reg2_d;
            rf_write_reg_q  <= rf_write_reg_d;
            rf_write_data_q <= rf_write_data_d;
            rf_regWrite_q   <= rf_regWrite_d;
            busy_q          <= busy_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rs_data   = rsp_rs_data_q;
    assign rsp_rt_data   = rsp_rt_data_q;
    assign rf_read_reg1  = rf_read_reg1_q;
    assign rf_read_reg2  = rf_read_reg2_q;
    assign rf_write_reg  = rf_write_reg_q;
    assign rf_write_data = rf_write_data_q;
    assign rf_regWrite   = rf_regWrite_q;
    assign busy          = busy_q;

endmodule
